// File: rtl/ddr_cmd_sequencer.sv
// ddr_cmd_sequencer
// Controller-side command issuer feeding the bank timing FSMs. It takes one
// read/write request at a time, tracks which row is open in every bank, and
// emits ACT/PR/PRA/RD/WR/REF pulses in the 19-bit bank-FSM command format.
// Commands are spaced by tRCD, tRP, tWR, BL and tRFC. Periodic refresh is
// scheduled from a free-running interval counter.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   req_valid  in   request present
//   req_ready  out  sequencer can accept (registered)
//   req_write  in   1 = write, 0 = read
//   req_bg     in   target bank group
//   req_ba     in   target bank
//   req_row    in   target row
//   commands   out  {ACT,BST,CFG,CKEH,CKEL,DPD,DPDX,MRR,MRW,PD,PDX,PR,PRA,RD,RDA,REF,SRF,WR,WRA}
//   bg, ba     out  bank group / bank of the current command
//   row        out  row of the last ACT (held otherwise)
//   busy       out  high whenever the FSM is not idle
//   ref_miss   out  sticky: a refresh tick arrived while one was still pending
module ddr_cmd_sequencer #(
  parameter int BGWIDTH       = 2,
  parameter int BANKGROUPS    = 2**BGWIDTH,
  parameter int BAWIDTH       = 2,
  parameter int BANKSPERGROUP = 2**BAWIDTH,
  parameter int ROWWIDTH      = 16,
  parameter int BL            = 8,
  parameter int T_RCD         = 17,
  parameter int T_RP          = 17,
  parameter int T_WR          = 14,
  parameter int T_RFC         = 34,
  parameter int T_REFI        = 10400
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [BGWIDTH-1:0]  req_bg,
  input  logic [BAWIDTH-1:0]  req_ba,
  input  logic [ROWWIDTH-1:0] req_row,
  output logic [18:0]         commands,
  output logic [BGWIDTH-1:0]  bg,
  output logic [BAWIDTH-1:0]  ba,
  output logic [ROWWIDTH-1:0] row,
  output logic                busy,
  output logic                ref_miss
);

  localparam int NBANKS = BANKGROUPS * BANKSPERGROUP;
  localparam int BANKW  = BGWIDTH + BAWIDTH;

  // Bit positions inside the command vector.
  localparam int CMD_ACT = 18;
  localparam int CMD_PR  = 7;
  localparam int CMD_PRA = 6;
  localparam int CMD_RD  = 5;
  localparam int CMD_REF = 3;
  localparam int CMD_WR  = 1;

  localparam int T_MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int T_MAX_B = (T_WR > T_RFC) ? T_WR : T_RFC;
  localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int T_MAX   = (T_MAX_C > BL) ? T_MAX_C : BL;
  localparam int CNTW    = $clog2(T_MAX + 1);
  localparam int REFW    = $clog2(T_REFI);

  // RW_ISSUE stays in the encoding to mirror the bank FSM state map but is
  // never entered: RD/WR is registered on the same edge the hit is accepted
  // or tRCD expires, so no separate issue cycle exists.
  typedef enum logic [2:0] {
    IDLE, PRE_WAIT, ACT_WAIT, RW_ISSUE, RD_WAIT, WR_WAIT, PRA_WAIT, REF_WAIT
  } state_t;

  state_t                          state_q, state_d;
  logic [CNTW-1:0]                 cnt_q, cnt_d;
  logic [REFW-1:0]                 ref_cnt_q, ref_cnt_d;
  logic                            ref_pending_q, ref_pending_d;
  logic                            ref_miss_q, ref_miss_d;
  logic                            req_ready_q, req_ready_d;
  logic [18:0]                     commands_q, commands_d;
  logic [BGWIDTH-1:0]              bg_q, bg_d;
  logic [BAWIDTH-1:0]              ba_q, ba_d;
  logic [ROWWIDTH-1:0]             row_q, row_d;
  logic                            cur_write_q, cur_write_d;
  logic [BGWIDTH-1:0]              cur_bg_q, cur_bg_d;
  logic [BAWIDTH-1:0]              cur_ba_q, cur_ba_d;
  logic [ROWWIDTH-1:0]             cur_row_q, cur_row_d;
  logic [NBANKS-1:0]               bank_open_q, bank_open_d;
  logic [NBANKS-1:0][ROWWIDTH-1:0] open_row_q, open_row_d;

  logic [BANKW-1:0] req_idx, cur_idx;
  logic             ref_wrap, ref_issue;

  assign req_idx  = {req_bg, req_ba};
  assign cur_idx  = {cur_bg_q, cur_ba_q};
  assign ref_wrap = (ref_cnt_q == REFW'(T_REFI - 1));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    commands_d  = '0;
    bg_d        = bg_q;
    ba_d        = ba_q;
    row_d       = row_q;
    cur_write_d = cur_write_q;
    cur_bg_d    = cur_bg_q;
    cur_ba_d    = cur_ba_q;
    cur_row_d   = cur_row_q;
    bank_open_d = bank_open_q;
    open_row_d  = open_row_q;
    ref_issue   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          cur_write_d = req_write;
          cur_bg_d    = req_bg;
          cur_ba_d    = req_ba;
          cur_row_d   = req_row;
          bg_d        = req_bg;
          ba_d        = req_ba;
          if (bank_open_q[req_idx] && open_row_q[req_idx] == req_row) begin
            commands_d[req_write ? CMD_WR : CMD_RD] = 1'b1;
            state_d = req_write ? WR_WAIT : RD_WAIT;
            cnt_d   = req_write ? CNTW'(T_WR - 1) : CNTW'(BL - 1);
          end else if (bank_open_q[req_idx]) begin
            commands_d[CMD_PR]   = 1'b1;
            bank_open_d[req_idx] = 1'b0;
            state_d              = PRE_WAIT;
            cnt_d                = CNTW'(T_RP - 1);
          end else begin
            commands_d[CMD_ACT]  = 1'b1;
            bank_open_d[req_idx] = 1'b1;
            open_row_d[req_idx]  = req_row;
            row_d                = req_row;
            state_d              = ACT_WAIT;
            cnt_d                = CNTW'(T_RCD - 1);
          end
        end else if (ref_pending_q) begin
          if (|bank_open_q) begin
            commands_d[CMD_PRA] = 1'b1;
            bank_open_d         = '0;
            state_d             = PRA_WAIT;
            cnt_d               = CNTW'(T_RP - 1);
          end else begin
            commands_d[CMD_REF] = 1'b1;
            ref_issue           = 1'b1;
            state_d             = REF_WAIT;
            cnt_d               = CNTW'(T_RFC - 1);
          end
        end
      end
      PRE_WAIT: begin
        if (cnt_q == '0) begin
          commands_d[CMD_ACT]  = 1'b1;
          bank_open_d[cur_idx] = 1'b1;
          open_row_d[cur_idx]  = cur_row_q;
          row_d                = cur_row_q;
          state_d              = ACT_WAIT;
          cnt_d                = CNTW'(T_RCD - 1);
        end
      end
      ACT_WAIT: begin
        if (cnt_q == '0) begin
          commands_d[cur_write_q ? CMD_WR : CMD_RD] = 1'b1;
          state_d = cur_write_q ? WR_WAIT : RD_WAIT;
          cnt_d   = cur_write_q ? CNTW'(T_WR - 1) : CNTW'(BL - 1);
        end
      end
      RD_WAIT, WR_WAIT, REF_WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
      end
      PRA_WAIT: begin
        if (cnt_q == '0) begin
          commands_d[CMD_REF] = 1'b1;
          ref_issue           = 1'b1;
          state_d             = REF_WAIT;
          cnt_d               = CNTW'(T_RFC - 1);
        end
      end
      default: state_d = IDLE;
    endcase

    // REF closes every bank regardless of how it was reached.
    if (ref_issue) bank_open_d = '0;

    ref_cnt_d     = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    // A tick on the same edge as REF re-arms the request rather than being lost.
    ref_pending_d = ref_wrap | (ref_pending_q & ~ref_issue);
    ref_miss_d    = ref_miss_q | (ref_wrap & ref_pending_q & ~ref_issue);
    // Ready only in idle with no refresh outstanding, so an accept can never
    // coincide with refresh service.
    req_ready_d   = (state_d == IDLE) && !ref_pending_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      ref_miss_q    <= 1'b0;
      req_ready_q   <= 1'b1;
      commands_q    <= '0;
      bg_q          <= '0;
      ba_q          <= '0;
      row_q         <= '0;
      cur_write_q   <= 1'b0;
      cur_bg_q      <= '0;
      cur_ba_q      <= '0;
      cur_row_q     <= '0;
      bank_open_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      ref_miss_q    <= ref_miss_d;
      req_ready_q   <= req_ready_d;
      commands_q    <= commands_d;
      bg_q          <= bg_d;
      ba_q          <= ba_d;
      row_q         <= row_d;
      cur_write_q   <= cur_write_d;
      cur_bg_q      <= cur_bg_d;
      cur_ba_q      <= cur_ba_d;
      cur_row_q     <= cur_row_d;
      bank_open_q   <= bank_open_d;
    end
  end

  // NOTE: the open-row table is not reset; an entry is only read when its
  // bank_open bit is set, and that bit is cleared by reset.
  always_ff @(posedge clk) begin
    open_row_q <= open_row_d;
  end

  assign req_ready = req_ready_q;
  assign commands  = commands_q;
  assign bg        = bg_q;
  assign ba        = ba_q;
  assign row       = row_q;
  assign busy      = (state_q != IDLE);
  assign ref_miss  = ref_miss_q;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed testbench for ddr_cmd_sequencer. Offsets are counted from the
// accept edge: offset k is sampled on the falling edge after the k-th rising
// edge following acceptance (offset 1 is the first command slot).
module tb_ddr_cmd_sequencer;

  localparam logic [18:0] C_ACT = 19'h40000;
  localparam logic [18:0] C_PR  = 19'h00080;
  localparam logic [18:0] C_PRA = 19'h00040;
  localparam logic [18:0] C_RD  = 19'h00020;
  localparam logic [18:0] C_REF = 19'h00008;
  localparam logic [18:0] C_WR  = 19'h00002;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_bg, req_ba;
  logic [15:0] req_row;
  logic [18:0] commands;
  logic [1:0]  bg, ba;
  logic [15:0] row;
  logic        busy, ref_miss;

  // Second instance with a deliberately short refresh interval and a long
  // tRFC so two ticks land before the first refresh completes.
  logic        req_valid2;
  logic        req_ready2;
  logic [18:0] commands2;
  logic [1:0]  bg2, ba2;
  logic [15:0] row2;
  logic        busy2, ref_miss2;

  int total = 0;
  int bad   = 0;
  int cyc;

  logic [18:0] cmd_log  [0:127];
  logic        rdy_log  [0:127];
  logic [15:0] row_log  [0:127];
  logic [3:0]  bgba_log [0:127];
  logic        busy_log [0:127];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  ddr_cmd_sequencer u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .commands(commands), .bg(bg), .ba(ba), .row(row), .busy(busy), .ref_miss(ref_miss)
  );

  ddr_cmd_sequencer #(.T_REFI(20), .T_RFC(50)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(1'b0), .req_bg(2'd0), .req_ba(2'd0), .req_row(16'd0),
    .commands(commands2), .bg(bg2), .ba(ba2), .row(row2), .busy(busy2), .ref_miss(ref_miss2)
  );

  task automatic watch(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cmd_log[k]  = commands;
      rdy_log[k]  = req_ready;
      row_log[k]  = row;
      bgba_log[k] = {bg, ba};
      busy_log[k] = busy;
    end
  endtask

  function automatic int first_ready(input int n);
    for (int k = 1; k <= n; k++) if (rdy_log[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int n_cmds(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (cmd_log[k] !== 19'h0) c++;
    return c;
  endfunction

  function automatic int n_not_onehot(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (cmd_log[k] !== 19'h0 && $countones(cmd_log[k]) != 1) c++;
    return c;
  endfunction

  // Caller is positioned on a falling edge; acceptance happens on the next rising edge.
  task automatic send(input logic w, input logic [1:0] b_g, input logic [1:0] b_a, input logic [15:0] r);
    req_write = w; req_bg = b_g; req_ba = b_a; req_row = r; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc != target && guard < 30000) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (cyc != target) begin bad++; $display("FAIL wait_cyc got=%0d want=%0d", cyc, target); end
  endtask

  task automatic test_reset();
    logic [18:0] acc;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_bg = '0; req_ba = '0; req_row = '0;
    req_valid2 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    acc = '0;
    repeat (5) begin @(negedge clk); acc |= commands; end
    total++; if (acc !== 19'h0)  begin bad++; $display("FAIL reset_cmds got=%h want=0", acc); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (ref_miss !== 1'b0) begin bad++; $display("FAIL reset_miss got=%b want=0", ref_miss); end
    total++; if ({bg, ba, row} !== 20'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", {bg, ba, row}); end
  endtask

  task automatic test_ref_miss();
    wait_cyc(21);
    total++; if (commands2 !== C_REF) begin bad++; $display("FAIL miss_ref_issue got=%h want=%h", commands2, C_REF); end
    wait_cyc(50);
    total++; if (ref_miss2 !== 1'b0) begin bad++; $display("FAIL miss_early got=%b want=0", ref_miss2); end
    total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL miss_busy got=%b want=1", busy2); end
    wait_cyc(65);
    total++; if (ref_miss2 !== 1'b1) begin bad++; $display("FAIL miss_set got=%b want=1", ref_miss2); end
  endtask

  task automatic test_read_closed();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rc_ready_pre got=%b want=1", req_ready); end
    send(1'b0, 2'd0, 2'd1, 16'h0012);
    watch(30);
    total++; if (cmd_log[1] !== C_ACT) begin bad++; $display("FAIL rc_act got=%h want=%h", cmd_log[1], C_ACT); end
    total++; if (row_log[1] !== 16'h0012) begin bad++; $display("FAIL rc_row got=%h want=0012", row_log[1]); end
    total++; if (bgba_log[1] !== 4'b0001) begin bad++; $display("FAIL rc_bgba got=%b want=0001", bgba_log[1]); end
    total++; if (busy_log[1] !== 1'b1) begin bad++; $display("FAIL rc_busy got=%b want=1", busy_log[1]); end
    total++; if (cmd_log[18] !== C_RD) begin bad++; $display("FAIL rc_rd got=%h want=%h", cmd_log[18], C_RD); end
    total++; if (n_cmds(30) != 2) begin bad++; $display("FAIL rc_count got=%0d want=2", n_cmds(30)); end
    total++; if (first_ready(30) != 26) begin bad++; $display("FAIL rc_ready got=%0d want=26", first_ready(30)); end
  endtask

  task automatic test_read_hit();
    send(1'b0, 2'd0, 2'd1, 16'h0012);
    watch(12);
    total++; if (cmd_log[1] !== C_RD) begin bad++; $display("FAIL hit_rd got=%h want=%h", cmd_log[1], C_RD); end
    total++; if (n_cmds(12) != 1) begin bad++; $display("FAIL hit_count got=%0d want=1", n_cmds(12)); end
    total++; if (first_ready(12) != 9) begin bad++; $display("FAIL hit_ready got=%0d want=9", first_ready(12)); end
  endtask

  task automatic test_write_miss();
    send(1'b1, 2'd0, 2'd1, 16'h0034);
    watch(52);
    total++; if (cmd_log[1] !== C_PR) begin bad++; $display("FAIL wm_pr got=%h want=%h", cmd_log[1], C_PR); end
    total++; if (cmd_log[18] !== C_ACT) begin bad++; $display("FAIL wm_act got=%h want=%h", cmd_log[18], C_ACT); end
    total++; if (row_log[18] !== 16'h0034) begin bad++; $display("FAIL wm_row got=%h want=0034", row_log[18]); end
    total++; if (cmd_log[35] !== C_WR) begin bad++; $display("FAIL wm_wr got=%h want=%h", cmd_log[35], C_WR); end
    total++; if (n_cmds(52) != 3) begin bad++; $display("FAIL wm_count got=%0d want=3", n_cmds(52)); end
    total++; if (n_not_onehot(52) != 0) begin bad++; $display("FAIL wm_onehot got=%0d want=0", n_not_onehot(52)); end
    total++; if (first_ready(52) != 49) begin bad++; $display("FAIL wm_ready got=%0d want=49", first_ready(52)); end
  endtask

  task automatic test_refresh();
    wait_cyc(10400);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rf_ready_drop got=%b want=0", req_ready); end
    watch(55);
    total++; if (cmd_log[1] !== C_PRA) begin bad++; $display("FAIL rf_pra got=%h want=%h", cmd_log[1], C_PRA); end
    total++; if (cmd_log[18] !== C_REF) begin bad++; $display("FAIL rf_ref got=%h want=%h", cmd_log[18], C_REF); end
    total++; if (n_cmds(55) != 2) begin bad++; $display("FAIL rf_count got=%0d want=2", n_cmds(55)); end
    total++; if (first_ready(55) != 52) begin bad++; $display("FAIL rf_ready got=%0d want=52", first_ready(55)); end
    send(1'b0, 2'd0, 2'd1, 16'h0034);
    watch(30);
    total++; if (cmd_log[1] !== C_ACT) begin bad++; $display("FAIL rf_reopen got=%h want=%h", cmd_log[1], C_ACT); end
    total++; if (cmd_log[18] !== C_RD) begin bad++; $display("FAIL rf_rd got=%h want=%h", cmd_log[18], C_RD); end
    total++; if (first_ready(30) != 26) begin bad++; $display("FAIL rf_ready2 got=%0d want=26", first_ready(30)); end
  endtask

  task automatic test_wrap_accept();
    wait_cyc(20799);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wa_ready_pre got=%b want=1", req_ready); end
    send(1'b0, 2'd1, 2'd2, 16'h0055);
    watch(80);
    total++; if (cmd_log[1] !== C_ACT) begin bad++; $display("FAIL wa_act got=%h want=%h", cmd_log[1], C_ACT); end
    total++; if (bgba_log[1] !== 4'b0110) begin bad++; $display("FAIL wa_bgba got=%b want=0110", bgba_log[1]); end
    total++; if (cmd_log[18] !== C_RD) begin bad++; $display("FAIL wa_rd got=%h want=%h", cmd_log[18], C_RD); end
    total++; if (cmd_log[27] !== C_PRA) begin bad++; $display("FAIL wa_pra got=%h want=%h", cmd_log[27], C_PRA); end
    total++; if (cmd_log[44] !== C_REF) begin bad++; $display("FAIL wa_ref got=%h want=%h", cmd_log[44], C_REF); end
    total++; if (n_cmds(80) != 4) begin bad++; $display("FAIL wa_count got=%0d want=4", n_cmds(80)); end
    total++; if (first_ready(80) != 78) begin bad++; $display("FAIL wa_ready got=%0d want=78", first_ready(80)); end
    total++; if (ref_miss !== 1'b0) begin bad++; $display("FAIL wa_no_miss got=%b want=0", ref_miss); end
  endtask

  task automatic test_reset_abort();
    send(1'b0, 2'd2, 2'd3, 16'h0077);
    watch(3);
    total++; if (cmd_log[1] !== C_ACT) begin bad++; $display("FAIL ab_act got=%h want=%h", cmd_log[1], C_ACT); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_busy got=%b want=0", busy); end
    watch(25);
    total++; if (n_cmds(25) != 0) begin bad++; $display("FAIL ab_quiet got=%0d want=0", n_cmds(25)); end
    total++; if (rdy_log[25] !== 1'b1) begin bad++; $display("FAIL ab_ready got=%b want=1", rdy_log[25]); end
  endtask

  initial begin
    test_reset();
    test_ref_miss();
    test_read_closed();
    test_read_hit();
    test_write_miss();
    test_refresh();
    test_wrap_accept();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
